// File: rtl/clock_set_ctrl_if.sv
// Front-panel / clock-core bus for the time-setting controller.
interface clock_set_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_dec;
  logic [7:0] cur_hh;
  logic [7:0] cur_mm;
  logic       cur_pm;
  logic       tick;
  logic       load;
  logic [7:0] load_hh;
  logic [7:0] load_mm;
  logic       load_pm;
  logic [1:0] state;
  logic       blink;

  // Buttons and clock readback side.
  modport master (
    output btn_mode, btn_inc, btn_dec, cur_hh, cur_mm, cur_pm,
    input  tick, load, load_hh, load_mm, load_pm, state, blink
  );

  // Controller side.
  modport slave (
    input  btn_mode, btn_inc, btn_dec, cur_hh, cur_mm, cur_pm,
    output tick, load, load_hh, load_mm, load_pm, state, blink
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Run / time-setting controller for a 12-hour BCD clock: generates the 1 Hz tick in RUN,
// edits a shadow hh:mm/pm copy in the set states and commits it with a one-cycle load.
module clock_set_ctrl #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic             clk,
  input  logic             reset,
  clock_set_ctrl_if.slave  ctrl_io
);

  localparam int unsigned PrescW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BlinkDiv = TICK_DIV / 4;
  localparam int unsigned BlinkW   = (BlinkDiv > 1) ? $clog2(BlinkDiv) : 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BlinkDiv - 1);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StSetHh  = 2'd1,
    StSetMm  = 2'd2,
    StCommit = 2'd3
  } state_e;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  state_e state_q, state_d;
  logic [2:0] btn, btn_q, btn_edge;
  logic mode_edge, inc_edge, dec_edge, edit_up, edit_dn;
  logic [7:0] hh_q, hh_d, mm_q, mm_d;
  logic pm_q, pm_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic tick_q, tick_d;
  logic blink_q, blink_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic set_next;

  // Rising-edge detection against the previous sampled level.
  always_comb begin
    btn       = {ctrl_io.btn_mode, ctrl_io.btn_inc, ctrl_io.btn_dec};
    btn_edge  = btn & ~btn_q;
    mode_edge = btn_edge[2];
    inc_edge  = btn_edge[1];
    dec_edge  = btn_edge[0];
    // Mode wins over edits; simultaneous inc and dec cancel.
    edit_up   = !mode_edge && inc_edge && !dec_edge;
    edit_dn   = !mode_edge && dec_edge && !inc_edge;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= StRun;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun:    if (mode_edge) state_d = StSetHh;
      StSetHh:  if (mode_edge) state_d = StSetMm;
      StSetMm:  if (mode_edge) state_d = StCommit;
      StCommit: state_d = StRun;
      default:  state_d = StRun;
    endcase
  end

  // FSM outputs.
  always_comb begin
    ctrl_io.state = state_q;
    ctrl_io.load  = (state_q == StCommit);
  end

  // Shadow capture on leaving RUN, then BCD edits of the field being set.
  always_comb begin
    hh_d = hh_q;
    mm_d = mm_q;
    pm_d = pm_q;
    case (state_q)
      StRun: begin
        if (mode_edge) begin
          hh_d = ctrl_io.cur_hh;
          mm_d = ctrl_io.cur_mm;
          pm_d = ctrl_io.cur_pm;
        end
      end
      StSetHh: begin
        if (edit_up) begin
          if (hh_q == 8'h12) begin
            hh_d = 8'h01;
          end else begin
            hh_d = bcd_inc(hh_q);
            if (hh_q == 8'h11) pm_d = ~pm_q;
          end
        end else if (edit_dn) begin
          if (hh_q == 8'h01) begin
            hh_d = 8'h12;
          end else begin
            hh_d = bcd_dec(hh_q);
            if (hh_q == 8'h12) pm_d = ~pm_q;
          end
        end
      end
      StSetMm: begin
        if (edit_up)      mm_d = (mm_q == 8'h59) ? 8'h00 : bcd_inc(mm_q);
        else if (edit_dn) mm_d = (mm_q == 8'h00) ? 8'h59 : bcd_dec(mm_q);
      end
      default: ;
    endcase
  end

  // Prescaler runs only in RUN; tick is registered off its terminal count.
  always_comb begin
    tick_d = (state_q == StRun) && (presc_q == PrescMax);
    if (state_q != StRun || presc_q == PrescMax) presc_d = '0;
    else                                         presc_d = presc_q + PrescW'(1);
  end

  // Blink phase restarts high on entry to SET_HH and runs through both set states.
  always_comb begin
    set_next    = (state_d == StSetHh) || (state_d == StSetMm);
    blink_d     = 1'b0;
    blink_cnt_d = '0;
    if (set_next) begin
      if (state_q == StRun) begin
        blink_d = 1'b1;
      end else if (blink_cnt_q == BlinkMax) begin
        blink_d = ~blink_q;
      end else begin
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q + BlinkW'(1);
      end
    end
  end

  // Datapath registers; button history resets high so held buttons give no edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_q       <= 3'b111;
      hh_q        <= 8'h12;
      mm_q        <= 8'h00;
      pm_q        <= 1'b0;
      presc_q     <= '0;
      tick_q      <= 1'b0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      btn_q       <= btn;
      hh_q        <= hh_d;
      mm_q        <= mm_d;
      pm_q        <= pm_d;
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign ctrl_io.tick    = tick_q;
  assign ctrl_io.load_hh = hh_q;
  assign ctrl_io.load_mm = mm_q;
  assign ctrl_io.load_pm = pm_q;
  assign ctrl_io.blink   = blink_q;

endmodule
